ahb_lite_sram_slave: RTL and testbench
======================================

Name: ahb_lite_sram_slave

Overview:
- AHB-Lite responder (slave) that completes transfers issued by the RISC master through ahb_lite_interconnect.
- Backed by a word-organised local memory of DEPTH 32-bit words.
- Supports byte, halfword and word access with programmable wait states and a two-cycle ERROR response.
- Plugs into any interconnect slave slot alongside the ALU and multiplier interfaces, using the same sl_/out_sl_ port set.

Parameters:
- W_ADDR, 32, width of sl_HADDR.
- W_BURST, 3, width of sl_HBURST (matches `W_BURST).
- DEPTH, 256, number of 32-bit words; any value 1..16384.
- WAIT_STATES, 1, HREADY-low cycles inserted in each OKAY data phase (0..15).

Ports:
- HCLK  input  1  bus clock; all state on rising edge.
- HRESET  input  1  asynchronous, active-high reset.
- sl_HSEL  input  1  slave select from interconnect.
- sl_HREADY  input  1  bus HREADY (previous transfer complete).
- sl_HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- sl_HBURST  input  W_BURST  burst type; ignored.
- sl_HSIZE  input  3  0=byte, 1=half, 2=word.
- sl_HADDR  input  W_ADDR  byte address.
- sl_HWRITE  input  1  1=write.
- sl_HWDATA  input  32  write data (data phase).
- out_sl_HREADY  output  1  slave ready.
- out_sl_HRESP  output  2  OKAY=0, ERROR=1.
- out_sl_HRDATA  output  32  read data.

Behaviour:
- Interface: one clock, HCLK. Reset HRESET is asynchronous and active-high.
- Reset values: state=IDLE, out_sl_HREADY=1, out_sl_HRESP=0, out_sl_HRDATA=0, wait counter=0. Memory contents are not reset.
- Accept condition: sl_HSEL & sl_HREADY & sl_HTRANS[1].
  - On accept, register HADDR, HSIZE and HWRITE, and set idx = HADDR[15:2].
  - A selected IDLE or BUSY transfer gets a zero-wait OKAY and causes no access.
- Error condition (evaluated at accept):
  - sl_HSIZE > 2; or
  - half access with HADDR[0]=1; or
  - word access with HADDR[1:0]!=0; or
  - idx >= DEPTH.
- State machine:
  - IDLE: HREADY=1, HRESP=OKAY, HRDATA=0.
    - Accept + error -> ERR1.
    - Accept + ok -> DATA, with cnt <= WAIT_STATES.
  - DATA: HRESP=OKAY.
    - cnt != 0: HREADY=0, cnt decrements.
    - cnt == 0: HREADY=1 and the transfer completes.
    - On completion: if a new accept occurs in the same cycle, go to DATA/ERR1 for it; otherwise go to IDLE.
  - ERR1: HREADY=0, HRESP=ERROR; unconditionally -> ERR2.
  - ERR2: HREADY=1, HRESP=ERROR. A new accept here is honoured exactly as in IDLE; otherwise -> IDLE.
- Write: in the completing DATA cycle, byte lanes selected by size and addr[1:0] (little-endian) are written from sl_HWDATA.
  - byte: lane addr[1:0].
  - half: lanes {addr[1],0} and {addr[1],1}.
  - word: all four lanes.
  - Unselected lanes are unchanged.
- Read: out_sl_HRDATA = mem[idx] (full word, all lanes) while in DATA for a read; 0 otherwise.
  - Read data is valid in the cycle out_sl_HREADY=1.
- Back-to-back write then read of the same address returns the new data. The write commits at the end of its data phase, before the read's data phase.
- The slave never accepts while it is driving HREADY=0. The bus gates this via sl_HREADY.
- HRESET asserted mid-transfer aborts immediately to the reset values. No memory write occurs for the aborted transfer.

Optional Feature:
- Macro: AHB_SRAM_SLAVE_ERR_EN.
- Defined: error handling exactly as above.
- Undefined: ERR1/ERR2 are never entered, and every transfer completes OKAY through DATA.
  - Misaligned access: low address bits are ignored (forced aligned).
  - HSIZE > 2: treated as word.
  - idx >= DEPTH: the write is dropped and a read returns 0.

Test Plan:
- Reset then idle: HRESET=1 for 3 cycles, release -> out_sl_HREADY=1, HRESP=0, HRDATA=0; an IDLE transfer gives a zero-wait OKAY.
- Word write/read, WAIT_STATES=1: write 0xDEADBEEF to 0x10, then read 0x10 -> each data phase shows exactly 1 HREADY-low cycle; read returns 0xDEADBEEF.
- Byte/half lanes: word 0x11223344 at 0x20; byte write 0xAA to 0x21; half write 0x5566 to 0x22 -> read 0x20 returns 0x5566AA44.
- Pipelined write->read, WAIT_STATES=0: NONSEQ write 0x12345678 to 0x40, immediately followed by NONSEQ read of 0x40 -> read data 0x12345678, no stall cycles.
- Error with AHB_SRAM_SLAVE_ERR_EN defined: word read at 0x02 -> HREADY 0 then 1 with HRESP=ERROR in both cycles; a following read of 0x00 returns OKAY. Without the macro: same read returns mem[0], OKAY.
- Reset mid-transfer: WAIT_STATES=3, assert HRESET during the second wait cycle of a write of 0xCAFEF00D to 0x08 -> outputs at reset values immediately; a later read of 0x08 returns its prior contents.

Source files
------------

// File: rtl/ahb_lite_sram_slave.sv
// rtl/ahb_lite_sram_slave.sv - AHB-Lite SRAM responder with wait states; define AHB_SRAM_SLAVE_ERR_EN for ERROR responses
module ahb_lite_sram_slave #(
  parameter int W_ADDR      = 32,
  parameter int W_BURST     = 3,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               sl_HSEL,
  input  logic               sl_HREADY,
  input  logic [1:0]         sl_HTRANS,
  input  logic [W_BURST-1:0] sl_HBURST,
  input  logic [2:0]         sl_HSIZE,
  input  logic [W_ADDR-1:0]  sl_HADDR,
  input  logic               sl_HWRITE,
  input  logic [31:0]        sl_HWDATA,
  output logic               out_sl_HREADY,
  output logic [1:0]         out_sl_HRESP,
  output logic [31:0]        out_sl_HRDATA
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [14:0] DEPTH_L    = 15'(DEPTH);
  localparam logic [3:0]  WS_L       = 4'(WAIT_STATES);
  localparam logic [1:0]  RESP_OKAY  = 2'd0;
  localparam logic [1:0]  RESP_ERROR = 2'd1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] idx_q, idx_d;
  logic [1:0]  lo_q, lo_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d;
  logic        oor_q, oor_d;

  logic [31:0] mem [DEPTH];

  logic        hready;
  logic        accept;
  logic        req_err;
  logic        req_oor;
  logic [13:0] req_idx;
  logic [1:0]  req_size;
  logic        done;
  logic        we;
  logic [3:0]  be;
  logic [31:0] rword;
  logic        unused_bits;

  // Burst type, upper address bits and the SEQ/NONSEQ distinction do not affect this slave
  assign unused_bits = ^{sl_HBURST, sl_HADDR[W_ADDR-1:16], sl_HTRANS[0]};

  assign req_idx = sl_HADDR[15:2];
  assign req_oor = ({1'b0, req_idx} >= DEPTH_L);
  // Oversized requests collapse to word; misaligned low bits are dropped by the lane decode
  assign req_size = (sl_HSIZE > 3'd2) ? 2'd2 : sl_HSIZE[1:0];
  // Our own ready is folded in so a stalled data phase can never be overtaken
  assign accept = sl_HSEL & sl_HREADY & sl_HTRANS[1] & hready;

`ifdef AHB_SRAM_SLAVE_ERR_EN
  assign req_err = (sl_HSIZE > 3'd2)
                 | ((sl_HSIZE == 3'd1) & sl_HADDR[0])
                 | ((sl_HSIZE == 3'd2) & (sl_HADDR[1:0] != 2'b00))
                 | req_oor;
`else
  assign req_err = 1'b0;
`endif

  assign done  = (state_q == S_DATA) && (cnt_q == 4'd0);
  assign we    = done & write_q & ~oor_q;
  assign rword = mem[idx_q[AW-1:0]];

  // State and captured address-phase register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 14'd0;
      lo_q    <= 2'd0;
      size_q  <= 2'd0;
      write_q <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      size_q  <= size_d;
      write_q <= write_d;
      oor_q   <= oor_d;
    end
  end

  // Next state: finish the current data phase, then take any newly accepted transfer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    size_d  = size_q;
    write_d = write_q;
    oor_d   = oor_q;
    case (state_q)
      S_DATA: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = S_IDLE;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      idx_d   = req_idx;
      lo_d    = sl_HADDR[1:0];
      size_d  = req_size;
      write_d = sl_HWRITE;
      oor_d   = req_oor;
      if (req_err) begin
        state_d = S_ERR1;
      end else begin
        state_d = S_DATA;
        cnt_d   = WS_L;
      end
    end
  end

  // Bus outputs decoded from the registered state only
  always_comb begin
    hready        = 1'b1;
    out_sl_HRESP  = RESP_OKAY;
    out_sl_HRDATA = 32'd0;
    case (state_q)
      S_DATA: begin
        hready = (cnt_q == 4'd0);
        if (!write_q && !oor_q) out_sl_HRDATA = rword;
      end
      S_ERR1: begin
        hready       = 1'b0;
        out_sl_HRESP = RESP_ERROR;
      end
      S_ERR2:  out_sl_HRESP = RESP_ERROR;
      default: ;
    endcase
  end

  assign out_sl_HREADY = hready;

  // Little-endian byte-lane enables from the captured size and low address bits
  always_comb begin
    case (size_q)
      2'd0:    be = 4'b0001 << lo_q;
      2'd1:    be = lo_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Memory commit at the completing data cycle; contents survive reset
  always_ff @(posedge HCLK) begin
    if (we && !HRESET) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx_q[AW-1:0]][8*k +: 8] <= sl_HWDATA[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb/tb_ahb_lite_sram_slave.sv - randomized scoreboard bench for ahb_lite_sram_slave
module tb_ahb_lite_sram_slave;

  localparam int DEPTH = 64;
  localparam int WS    = 2;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        sl_HSEL;
  logic        sl_HREADY;
  logic [1:0]  sl_HTRANS;
  logic [2:0]  sl_HBURST;
  logic [2:0]  sl_HSIZE;
  logic [31:0] sl_HADDR;
  logic        sl_HWRITE;
  logic [31:0] sl_HWDATA;
  logic        out_sl_HREADY;
  logic [1:0]  out_sl_HRESP;
  logic [31:0] out_sl_HRDATA;

  ahb_lite_sram_slave #(
    .W_ADDR(32), .W_BURST(3), .DEPTH(DEPTH), .WAIT_STATES(WS)
  ) u_dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .sl_HSEL(sl_HSEL), .sl_HREADY(sl_HREADY), .sl_HTRANS(sl_HTRANS),
    .sl_HBURST(sl_HBURST), .sl_HSIZE(sl_HSIZE), .sl_HADDR(sl_HADDR),
    .sl_HWRITE(sl_HWRITE), .sl_HWDATA(sl_HWDATA),
    .out_sl_HREADY(out_sl_HREADY), .out_sl_HRESP(out_sl_HRESP),
    .out_sl_HRDATA(out_sl_HRDATA)
  );

  always #5 HCLK = ~HCLK;
  assign sl_HREADY = out_sl_HREADY;

  typedef struct {
    bit          idle;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          hc;
    logic [31:0] cv;
  } req_t;

  req_t        q[$];
  logic [7:0]  mdl [DEPTH*4];
  logic [31:0] pend_wdata = 32'd0;
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] pf(int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  function automatic logic [31:0] mdl_word(int i);
    return {mdl[i*4+3], mdl[i*4+2], mdl[i*4+1], mdl[i*4]};
  endfunction

  // Reference: transactions complete in order; a write changes the addressed bytes
  function automatic void complete(req_t r, logic [1:0] resp, logic [31:0] rdata,
                                   int w, bit se, bit so);
    logic [1:0]  er;
    int          ew;
    logic [31:0] ed;
    int          idx;
    bit          oor;
    bit          err;
    int          nb;
    int          base;
    int          lane;
    ed  = 32'd0;
    idx = int'(r.addr[15:2]);
    oor = (idx >= DEPTH);
    err = 1'b0;
    if (r.idle) begin
      er = 2'd0;
      ew = 0;
    end else begin
`ifdef AHB_SRAM_SLAVE_ERR_EN
      err = oor || (r.size > 3'd2) || (r.size == 3'd1 && r.addr[0])
            || (r.size == 3'd2 && r.addr[1:0] != 2'b00);
`endif
      if (err) begin
        er = 2'd1;
        ew = 1;
      end else begin
        er = 2'd0;
        ew = WS;
        if (r.wr) begin
          if (!oor) begin
            nb   = (r.size == 3'd0) ? 1 : (r.size == 3'd1) ? 2 : 4;
            base = int'(r.addr[1:0]) & ~(nb - 1);
            for (int k = 0; k < nb; k++) begin
              lane = base + k;
              mdl[idx*4+lane] = r.wdata[8*lane +: 8];
            end
          end
        end else if (!oor) begin
          ed = mdl_word(idx);
        end
      end
    end
    chk("resp", 32'(resp), 32'(er));
    chk("waits", 32'(w), 32'(ew));
    if (ew > 0) chk("wait_resp", 32'((er == 2'd1) ? so : se), 32'd0);
    chk("rdata", rdata, ed);
    if (r.hc) chk("const", rdata, r.cv);
  endfunction

  int mon_waits = 0;
  bit mon_se = 1'b0;
  bit mon_so = 1'b0;

  // Monitor: count stall cycles of the head data phase and score it when HREADY rises
  always @(negedge HCLK) begin
    if (HRESET === 1'b1 || q.size() == 0) begin
      mon_waits = 0; mon_se = 1'b0; mon_so = 1'b0;
    end else if (out_sl_HREADY !== 1'b1) begin
      mon_waits++;
      if (out_sl_HRESP == 2'd1) mon_se = 1'b1; else mon_so = 1'b1;
      if (mon_waits > 40) begin
        chk("stall_timeout", 32'(mon_waits), 32'd40);
        void'(q.pop_front());
        mon_waits = 0; mon_se = 1'b0; mon_so = 1'b0;
      end
    end else begin
      complete(q.pop_front(), out_sl_HRESP, out_sl_HRDATA, mon_waits, mon_se, mon_so);
      mon_waits = 0; mon_se = 1'b0; mon_so = 1'b0;
    end
  end

  task automatic issue(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit hc, input logic [31:0] cv);
    req_t r;
    int   g;
    @(negedge HCLK);
    sl_HWDATA = pend_wdata;
    sl_HSEL   = 1'b1;
    sl_HTRANS = trans;
    sl_HWRITE = wr;
    sl_HSIZE  = size;
    sl_HADDR  = addr;
    sl_HBURST = 3'($urandom_range(0, 7));
    g = 0;
    while (out_sl_HREADY !== 1'b1 && g < 50) begin
      @(negedge HCLK);
      g++;
    end
    if (g >= 50) chk("addr_phase_timeout", 32'(g), 32'd0);
    @(posedge HCLK);
    r.idle  = !trans[1];
    r.wr    = wr;
    r.size  = size;
    r.addr  = addr;
    r.wdata = wdata;
    r.hc    = hc;
    r.cv    = cv;
    q.push_back(r);
    pend_wdata = wdata;
  endtask

  task automatic bus_idle();
    @(negedge HCLK);
    sl_HWDATA = pend_wdata;
    sl_HSEL   = 1'b0;
    sl_HTRANS = 2'd0;
  endtask

  task automatic drain();
    int g;
    bus_idle();
    g = 0;
    while (q.size() != 0 && g < 100) begin
      @(negedge HCLK);
      g++;
    end
    if (g >= 100) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [31:0] ad;
    int          rr;
    HRESET = 1'b1;
    sl_HSEL = 1'b0; sl_HTRANS = 2'd0; sl_HBURST = 3'd0; sl_HSIZE = 3'd0;
    sl_HADDR = 32'd0; sl_HWRITE = 1'b0; sl_HWDATA = 32'd0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("reset_hready", 32'(out_sl_HREADY), 32'd1);
    chk("reset_hresp", 32'(out_sl_HRESP), 32'd0);
    chk("reset_hrdata", out_sl_HRDATA, 32'd0);

    issue(2'd0, 1'b0, 3'd2, 32'h10, 32'd0, 1'b0, 32'd0);
    issue(2'd1, 1'b1, 3'd2, 32'h14, 32'd0, 1'b0, 32'd0);

    for (int i = 0; i < DEPTH; i++) issue(2'd2, 1'b1, 3'd2, 32'(i * 4), pf(i), 1'b0, 32'd0);
    drain();

    // Reset during the second wait cycle of a write must drop that write
    issue(2'd2, 1'b1, 3'd2, 32'h08, 32'hCAFE_F00D, 1'b0, 32'd0);
    bus_idle();
    @(posedge HCLK);
    #2;
    chk("in_second_wait", 32'(out_sl_HREADY), 32'd0);
    HRESET = 1'b1;
    #1;
    chk("abort_hready", 32'(out_sl_HREADY), 32'd1);
    chk("abort_hresp", 32'(out_sl_HRESP), 32'd0);
    chk("abort_hrdata", out_sl_HRDATA, 32'd0);
    q.delete();
    repeat (2) @(posedge HCLK);
    #2;
    HRESET = 1'b0;
    issue(2'd2, 1'b0, 3'd2, 32'h08, 32'd0, 1'b1, pf(2));

    issue(2'd2, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0);
    issue(2'd2, 1'b0, 3'd2, 32'h10, 32'd0, 1'b1, 32'hDEAD_BEEF);

    issue(2'd2, 1'b1, 3'd2, 32'h20, 32'h1122_3344, 1'b0, 32'd0);
    issue(2'd2, 1'b1, 3'd0, 32'h21, 32'h0000_AA00, 1'b0, 32'd0);
    issue(2'd3, 1'b1, 3'd1, 32'h22, 32'h5566_0000, 1'b0, 32'd0);
    issue(2'd2, 1'b0, 3'd2, 32'h20, 32'd0, 1'b1, 32'h5566_AA44);

    issue(2'd2, 1'b1, 3'd2, 32'h40, 32'h1234_5678, 1'b0, 32'd0);
    issue(2'd2, 1'b0, 3'd2, 32'h40, 32'd0, 1'b1, 32'h1234_5678);

`ifdef AHB_SRAM_SLAVE_ERR_EN
    issue(2'd2, 1'b0, 3'd2, 32'h02, 32'd0, 1'b1, 32'd0);
`else
    issue(2'd2, 1'b0, 3'd2, 32'h02, 32'd0, 1'b1, pf(0));
`endif
    issue(2'd2, 1'b0, 3'd2, 32'h00, 32'd0, 1'b1, pf(0));
    issue(2'd2, 1'b0, 3'd2, 32'(DEPTH * 4), 32'd0, 1'b0, 32'd0);
    issue(2'd2, 1'b1, 3'd2, 32'(DEPTH * 4 + 8), 32'h0BAD_0BAD, 1'b0, 32'd0);

    for (int n = 0; n < 200; n++) begin
      rr = int'($urandom_range(0, 15));
      tr = (rr == 0) ? 2'd0 : (rr == 1) ? 2'd1 : (rr < 5) ? 2'd3 : 2'd2;
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      ad = 32'($urandom_range(0, DEPTH * 4 + 31));
      if ($urandom_range(0, 7) == 0) ad = ad | 32'h0005_0000;
      issue(tr, 1'($urandom_range(0, 1)), sz, ad, 32'($urandom), 1'b0, 32'd0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
